nonce_collector: RTL

NONCE_COLLECTOR -- requirements
Module: nonce_collector

---
 rtl/hub_pkg.sv | 18 +
 rtl/nonce_fifo.sv | 63 ++++++
 rtl/nonce_collector.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hub_pkg.sv
// Shared definitions for the nonce collection hub.
// Contents:
//   NONCE_W     - width of one nonce word
//   DROP_W      - width of the saturating drop counter
//   out_state_t - UART-side output FSM states
package hub_pkg;

    localparam int unsigned NONCE_W = 32;
    localparam int unsigned DROP_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } out_state_t;

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous single-clock FIFO for found nonces.
// Ports:
//   i_clk, i_reset         - clock, synchronous active-high reset
//   i_push, i_wr_data      - write request and data (accepted when not full, or full with a pop)
//   i_pop, o_rd_data       - read request and head-of-queue data (first-word fall-through)
//   o_full, o_empty        - status flags
//   o_count                - occupancy, 0..2**FIFO_AW
module nonce_fifo #(
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned DW      = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [DW-1:0]    i_wr_data,
    input  logic             i_pop,
    output logic [DW-1:0]    o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [FIFO_AW:0] o_count
);

    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    logic [DW-1:0]      r_mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rptr];

    // When full, a simultaneous pop frees the slot being written this edge.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nonce_collector.sv
// Collects found nonces from SLAVES hasher channels, queues them in a FIFO
// and hands them one at a time to a UART transmitter.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   new_nonces    - per-channel one-cycle found strobe
//   slave_nonces  - channel i nonce at [32i+31:32i]
//   golden_nonce  - word presented to the UART, held until the next pop
//   serial_send   - one-cycle transmit request
//   serial_busy   - UART transmitting
//   pending       - per-channel capture slot occupied
//   fifo_count    - FIFO occupancy
//   drop_count    - nonces lost to slot overwrite, saturating
module nonce_collector
    import hub_pkg::*;
#(
    parameter int unsigned SLAVES       = 2,
    parameter int unsigned FIFO_AW      = 3,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SLAVES-1:0]         new_nonces,
    input  logic [NONCE_W*SLAVES-1:0] slave_nonces,
    output logic [NONCE_W-1:0]        golden_nonce,
    output logic                      serial_send,
    input  logic                      serial_busy,
    output logic [SLAVES-1:0]         pending,
    output logic [FIFO_AW:0]          fifo_count,
    output logic [DROP_W-1:0]         drop_count
);

    localparam int unsigned IW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    logic [NONCE_W-1:0] r_slot [SLAVES];
    logic [SLAVES-1:0]  r_pending;
    logic [IW-1:0]      r_last;
    logic [DROP_W-1:0]  r_drop;
    out_state_t         r_state;
    out_state_t         w_next;
    logic [TW-1:0]      r_tmo;
    logic [TW-1:0]      w_tmo_next;
    logic [NONCE_W-1:0] r_golden;
    logic               r_send;

    logic               w_hi_any, w_lo_any;
    logic [IW-1:0]      w_hi_idx, w_lo_idx, w_grant_idx;
    logic               w_push, w_pop;
    logic [SLAVES-1:0]  w_drain;
    logic [SLAVES-1:0]  w_drop_vec;
    logic [4:0]         w_drop_n;
    logic [DROP_W:0]    w_drop_sum;
    logic               w_full, w_empty;
    logic [NONCE_W-1:0] w_head;

    assign pending      = r_pending;
    assign drop_count   = r_drop;
    assign golden_nonce = r_golden;
    assign serial_send  = r_send;

    // Round-robin: first pending channel above the last grant, else wrap to
    // the lowest pending channel.
    always_comb begin
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int unsigned i = 0; i < SLAVES; i++) begin
            if (r_pending[i] && (i > 32'(r_last)) && !w_hi_any) begin
                w_hi_any = 1'b1;
                w_hi_idx = IW'(i);
            end
            if (r_pending[i] && !w_lo_any) begin
                w_lo_any = 1'b1;
                w_lo_idx = IW'(i);
            end
        end
        w_grant_idx = w_hi_any ? w_hi_idx : w_lo_idx;
    end

    assign w_push = w_lo_any && (!w_full || w_pop);

    always_comb begin
        w_drain    = '0;
        w_drop_vec = '0;
        w_drop_n   = '0;
        for (int unsigned i = 0; i < SLAVES; i++) begin
            w_drain[i]    = w_push && (w_grant_idx == IW'(i));
            w_drop_vec[i] = new_nonces[i] && r_pending[i] && !w_drain[i];
            w_drop_n      = w_drop_n + 5'(w_drop_vec[i]);
        end
        w_drop_sum = {1'b0, r_drop} + (DROP_W+1)'(w_drop_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_last    <= IW'(SLAVES - 1);
            r_drop    <= '0;
        end else begin
            for (int unsigned i = 0; i < SLAVES; i++) begin
                if (new_nonces[i]) begin
                    r_slot[i]    <= slave_nonces[i*NONCE_W +: NONCE_W];
                    r_pending[i] <= 1'b1;
                end else if (w_drain[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
            if (w_push) r_last <= w_grant_idx;
            r_drop <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
        end
    end

    nonce_fifo #(
        .FIFO_AW (FIFO_AW),
        .DW      (NONCE_W)
    ) u_fifo (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_push    (w_push),
        .i_wr_data (r_slot[w_grant_idx]),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (fifo_count)
    );

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_tmo_next = r_tmo;
        case (r_state)
            IDLE: begin
                if (!w_empty && !serial_busy) begin
                    w_pop  = 1'b1;
                    w_next = SEND;
                end
            end
            SEND: begin
                w_next     = WAIT_BUSY;
                w_tmo_next = '0;
            end
            WAIT_BUSY: begin
                if (serial_busy) begin
                    w_next = WAIT_DONE;
                end else if (r_tmo == TMO_LAST) begin
                    w_next = IDLE;
                end else begin
                    w_tmo_next = r_tmo + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!serial_busy) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // serial_send is registered alongside the pop so it is high exactly
    // while the FSM sits in SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_tmo    <= '0;
            r_golden <= '0;
            r_send   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tmo   <= w_tmo_next;
            r_send  <= w_pop;
            if (w_pop) r_golden <= w_head;
        end
    end

endmodule
